// File: rtl/mem_arbiter.sv
// Arbiter that shares one byte-serial memory controller between ICache fetches
// and load/store unit accesses, with starvation protection and flush handling.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,

  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,

  input  logic        lsb_req,
  input  logic [31:0] lsb_addr,
  input  logic        lsb_write,
  input  logic [1:0]  lsb_size,
  input  logic        lsb_signed,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,

  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_wdata,
  input  logic        m_done,
  input  logic [31:0] m_rdata
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IC,
    BUSY_LSB,
    DRAIN,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             owner_lsb;
  logic             ld_signed;
  logic [31:0]      result;

  logic             forced;
  logic             grant_lsb;
  logic             grant_ic;
  logic [31:0]      wdata_masked;
  logic [31:0]      load_ext;

  // The LSB wins by default; a waiting fetch takes the bus once the LSB has
  // been granted STARVE_LIMIT times in a row while it was pending.
  always_comb begin
    forced    = ic_req && (starve_cnt == CNT_MAX);
    grant_lsb = lsb_req && !forced;
    grant_ic  = ic_req && !grant_lsb;
  end

  always_comb begin
    case (lsb_size)
      2'd0:    wdata_masked = {24'd0, lsb_wdata[7:0]};
      2'd1:    wdata_masked = {16'd0, lsb_wdata[15:0]};
      default: wdata_masked = lsb_wdata;
    endcase
  end

  always_comb begin
    case (m_size)
      2'd0:    load_ext = {{24{ld_signed & m_rdata[7]}}, m_rdata[7:0]};
      2'd1:    load_ext = {{16{ld_signed & m_rdata[15]}}, m_rdata[15:0]};
      default: load_ext = m_rdata;
    endcase
  end

  // NOTE: every register here updates with <= so all branches see the
  // pre-edge values; mixing in = would make the result order-dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_lsb  <= 1'b0;
      ld_signed  <= 1'b0;
      result     <= '0;
      m_valid    <= 1'b0;
      m_addr     <= '0;
      m_write    <= 1'b0;
      m_size     <= '0;
      m_wdata    <= '0;
      ic_done    <= 1'b0;
      lsb_done   <= 1'b0;
      ic_data    <= '0;
      lsb_rdata  <= '0;
    end else if (rdy) begin
      ic_done  <= 1'b0;
      lsb_done <= 1'b0;

      case (state)
        IDLE: begin
          if (!clear) begin
            if (grant_lsb) begin
              m_valid   <= 1'b1;
              m_addr    <= lsb_addr;
              m_write   <= lsb_write;
              m_size    <= lsb_size;
              m_wdata   <= wdata_masked;
              ld_signed <= lsb_signed;
              owner_lsb <= 1'b1;
              state     <= BUSY_LSB;
              if (ic_req && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + CNT_ONE;
              end
            end else if (grant_ic) begin
              m_valid    <= 1'b1;
              m_addr     <= ic_addr;
              m_write    <= 1'b0;
              m_size     <= 2'd2;
              m_wdata    <= '0;
              owner_lsb  <= 1'b0;
              starve_cnt <= '0;
              state      <= BUSY_IC;
            end
          end
        end

        BUSY_IC: begin
          if (m_done) begin
            m_valid <= 1'b0;
            result  <= m_rdata;
            state   <= clear ? IDLE : RESP;
          end else if (clear) begin
            state <= DRAIN;
          end
        end

        // Stores already committed by the core are never abandoned by a flush.
        BUSY_LSB: begin
          if (m_done) begin
            m_valid <= 1'b0;
            result  <= load_ext;
            state   <= (clear && !m_write) ? IDLE : RESP;
          end else if (clear && !m_write) begin
            state <= DRAIN;
          end
        end

        // The controller cannot be cancelled, so wait out the flushed access.
        DRAIN: begin
          if (m_done) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end

        RESP: begin
          state <= IDLE;
          if (owner_lsb) begin
            if (m_write) begin
              lsb_done <= 1'b1;
            end else if (!clear) begin
              lsb_done  <= 1'b1;
              lsb_rdata <= result;
            end
          end else if (!clear) begin
            ic_done <= 1'b1;
            ic_data <= result;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        lsb_req;
  logic [31:0] lsb_addr;
  logic        lsb_write;
  logic [1:0]  lsb_size;
  logic        lsb_signed;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        m_valid;
  logic [31:0] m_addr;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_wdata;
  logic        m_done;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_write(lsb_write),
    .lsb_size(lsb_size), .lsb_signed(lsb_signed), .lsb_wdata(lsb_wdata),
    .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write), .m_size(m_size),
    .m_wdata(m_wdata), .m_done(m_done), .m_rdata(m_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] store_data(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return d & 32'h0000_00FF;
    if (sz == 2'd1) return d & 32'h0000_FFFF;
    return d;
  endfunction

  function automatic logic [31:0] load_data(input logic [31:0] raw, input logic [1:0] sz,
                                            input logic sgn);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = raw & 32'h0000_00FF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = raw & 32'h0000_FFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    lsb_req = 1'b0; lsb_addr = '0; lsb_write = 1'b0; lsb_size = '0;
    lsb_signed = 1'b0; lsb_wdata = '0;
    m_done = 1'b0; m_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_lsb(input logic [31:0] a, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd);
    lsb_req = 1'b1; lsb_addr = a; lsb_write = w; lsb_size = sz;
    lsb_signed = sg; lsb_wdata = wd;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, m_valid, 1);
  endtask

  // Controller side: hold m_done low for lat cycles, then pulse it once.
  // Returns at the negedge right after the edge that sampled m_done.
  task automatic serve(input int lat, input logic [31:0] data);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("m_valid_held", m_valid, 1);
    end
    m_done = 1'b1; m_rdata = data;
    @(negedge clk);
    m_done = 1'b0;
  endtask

  // Random-phase model state
  bit          ic_pend, lsb_pend, busy, cur_lsb, cur_write, cur_sgn, exp_lsb;
  logic [1:0]  cur_size;
  int          lat_left, done_wait, starve;
  logic [31:0] exp_res, last_ic, last_lsb;

  initial begin
    // Reset values
    do_reset();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_write", m_write, 0);
    check("rst_m_size", m_size, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_ic_done", ic_done, 0);
    check("rst_lsb_done", lsb_done, 0);
    check("rst_ic_data", ic_data, 0);
    check("rst_lsb_rdata", lsb_rdata, 0);

    // Instruction fetch
    ic_req = 1'b1; ic_addr = 32'h100;
    wait_valid("ic_grant");
    check("ic_m_addr", m_addr, 32'h100);
    check("ic_m_size", m_size, 2);
    check("ic_m_write", m_write, 0);
    serve(3, 32'h00C0_FFEE);
    check("ic_m_valid_drop", m_valid, 0);
    check("ic_not_early", ic_done, 0);
    @(negedge clk);
    check("ic_done", ic_done, 1);
    check("ic_data", ic_data, 32'h00C0_FFEE);
    check("ic_no_lsb_done", lsb_done, 0);
    ic_req = 1'b0;
    @(negedge clk);
    check("ic_done_one_cycle", ic_done, 0);
    check("ic_data_hold", ic_data, 32'h00C0_FFEE);

    // Signed byte load, then unsigned half load
    set_lsb(32'h200, 1'b0, 2'd0, 1'b1, 32'h0);
    wait_valid("lb_grant");
    check("lb_m_size", m_size, 0);
    serve(2, 32'h0000_00F0);
    @(negedge clk);
    check("lb_done", lsb_done, 1);
    check("lb_rdata", lsb_rdata, 32'hFFFF_FFF0);
    lsb_req = 1'b0;
    @(negedge clk);
    set_lsb(32'h204, 1'b0, 2'd1, 1'b0, 32'h0);
    wait_valid("lhu_grant");
    serve(1, 32'h0000_F0F0);
    @(negedge clk);
    check("lhu_done", lsb_done, 1);
    check("lhu_rdata", lsb_rdata, 32'h0000_F0F0);
    lsb_req = 1'b0;

    // Starvation limit with both requests held
    do_reset();
    ic_req = 1'b1; ic_addr = 32'h1000;
    set_lsb(32'h2000, 1'b0, 2'd2, 1'b0, 32'h0);
    for (int g = 0; g < 10; g++) begin
      exp_lsb = (g % 5) != 4;
      wait_valid("starve_grant");
      check("grant_order", m_addr == 32'h2000, exp_lsb);
      serve(1, g);
      @(negedge clk);
      check("starve_done", lsb_done, exp_lsb);
    end
    ic_req = 1'b0; lsb_req = 1'b0;
    @(negedge clk);

    // Flush during a fetch: drain without a pulse
    ic_req = 1'b1; ic_addr = 32'h300;
    wait_valid("clr_ic_grant");
    clear = 1'b1; ic_req = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    check("clr_ic_valid", m_valid, 1);
    check("clr_ic_addr", m_addr, 32'h300);
    serve(2, 32'h1111_1111);
    check("clr_ic_valid_drop", m_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr_ic_no_done", ic_done, 0);
    end

    // Flush during a load: drain without a pulse
    set_lsb(32'h400, 1'b0, 2'd2, 1'b0, 32'h0);
    wait_valid("clr_ld_grant");
    clear = 1'b1; lsb_req = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    check("clr_ld_valid", m_valid, 1);
    serve(1, 32'h2222_2222);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr_ld_no_done", lsb_done, 0);
    end

    // Flush during a store is ignored
    set_lsb(32'h500, 1'b1, 2'd2, 1'b0, 32'h1234_5678);
    wait_valid("clr_sw_grant");
    check("sw_m_wdata", m_wdata, 32'h1234_5678);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    serve(1, 32'h0);
    @(negedge clk);
    check("clr_sw_done", lsb_done, 1);
    lsb_req = 1'b0;
    @(negedge clk);

    // Flush and completion together: load loses its pulse, store keeps it
    set_lsb(32'h600, 1'b0, 2'd2, 1'b0, 32'h0);
    wait_valid("clr_md_ld_grant");
    m_done = 1'b1; m_rdata = 32'h3333_3333; clear = 1'b1; lsb_req = 1'b0;
    @(negedge clk);
    m_done = 1'b0; clear = 1'b0;
    check("clr_md_ld_valid", m_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr_md_ld_no_done", lsb_done, 0);
    end
    set_lsb(32'h640, 1'b1, 2'd2, 1'b0, 32'h4444_4444);
    wait_valid("clr_md_sw_grant");
    m_done = 1'b1; clear = 1'b1;
    @(negedge clk);
    m_done = 1'b0; clear = 1'b0;
    @(negedge clk);
    check("clr_md_sw_done", lsb_done, 1);
    lsb_req = 1'b0;
    @(negedge clk);

    // Flush while the response is pending
    set_lsb(32'h700, 1'b0, 2'd2, 1'b0, 32'h0);
    wait_valid("clr_resp_grant");
    serve(1, 32'h0000_DEAD);
    clear = 1'b1; lsb_req = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    check("clr_resp_no_done", lsb_done, 0);

    // Flush in IDLE ignores a request sampled the same cycle
    set_lsb(32'h780, 1'b0, 2'd2, 1'b0, 32'h0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_idle_no_grant", m_valid, 0);
    @(negedge clk);
    check("clr_idle_late_grant", m_valid, 1);
    serve(1, 32'h5);
    @(negedge clk);
    check("clr_idle_done", lsb_done, 1);
    lsb_req = 1'b0;
    @(negedge clk);

    // Byte store masking and a freeze in the middle of the access
    set_lsb(32'h800, 1'b1, 2'd0, 1'b0, 32'hAABB_CCDD);
    wait_valid("sb_grant");
    check("sb_m_wdata", m_wdata, 32'h0000_00DD);
    check("sb_m_write", m_write, 1);
    rdy = 1'b0; m_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("frz_m_valid", m_valid, 1);
      check("frz_m_addr", m_addr, 32'h800);
      check("frz_m_wdata", m_wdata, 32'h0000_00DD);
      check("frz_no_done", lsb_done, 0);
    end
    m_done = 1'b0; rdy = 1'b1;
    serve(2, 32'h0);
    @(negedge clk);
    check("frz_resume_done", lsb_done, 1);
    lsb_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a load
    set_lsb(32'h900, 1'b0, 2'd2, 1'b0, 32'h0);
    wait_valid("rst_mid_grant");
    rst = 1'b1; m_done = 1'b1; m_rdata = 32'h55;
    @(negedge clk);
    rst = 1'b0; m_done = 1'b0; lsb_req = 1'b0;
    check("rst_mid_m_valid", m_valid, 0);
    check("rst_mid_m_addr", m_addr, 0);
    check("rst_mid_m_size", m_size, 0);
    check("rst_mid_lsb_rdata", lsb_rdata, 0);
    check("rst_mid_ic_data", ic_data, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", lsb_done, 0);
    end

    // Random traffic against the transaction-level model
    do_reset();
    ic_pend = 0; lsb_pend = 0; busy = 0; cur_lsb = 0; cur_write = 0;
    done_wait = 0; starve = 0; lat_left = 0; last_ic = '0; last_lsb = '0;
    for (int cyc = 0; cyc < 3300; cyc++) begin
      @(negedge clk);
      if (rdy) begin
        check("rnd_ic_done", ic_done, done_wait == 1 && !cur_lsb);
        check("rnd_lsb_done", lsb_done, done_wait == 1 && cur_lsb);
        if (done_wait == 1) begin
          if (cur_lsb) begin
            lsb_pend = 0;
            if (!cur_write) last_lsb = exp_res;
          end else begin
            ic_pend = 0;
            last_ic = exp_res;
          end
          done_wait = 0;
        end
        check("rnd_ic_data", ic_data, last_ic);
        check("rnd_lsb_rdata", lsb_rdata, last_lsb);

        if (m_done) begin
          m_done = 1'b0; busy = 0; done_wait = 1;
        end else if (!busy && m_valid) begin
          exp_lsb = lsb_pend && !(ic_pend && starve == LIMIT);
          check("rnd_grant_has_req", ic_pend || lsb_pend, 1);
          check("rnd_grant_addr", m_addr, exp_lsb ? lsb_addr : ic_addr);
          check("rnd_grant_write", m_write, exp_lsb && lsb_write);
          check("rnd_grant_size", m_size, exp_lsb ? lsb_size : 2'd2);
          if (exp_lsb && lsb_write)
            check("rnd_grant_wdata", m_wdata, store_data(lsb_wdata, lsb_size));
          if (exp_lsb) begin
            if (ic_pend && starve < LIMIT) starve++;
          end else begin
            starve = 0;
          end
          busy = 1; cur_lsb = exp_lsb; cur_write = exp_lsb && lsb_write;
          cur_size = lsb_size; cur_sgn = lsb_signed;
          lat_left = int'($urandom_range(0, 3));
        end
        check("rnd_m_valid", m_valid, busy);

        if (busy) begin
          if (lat_left == 0) begin
            m_done = 1'b1; m_rdata = $urandom;
            exp_res = cur_lsb ? load_data(m_rdata, cur_size, cur_sgn) : m_rdata;
          end else begin
            lat_left--;
          end
        end

        if (!ic_pend && cyc < 3000 && $urandom_range(0, 2) == 0) begin
          ic_pend = 1; ic_addr = $urandom & 32'h7FFF_FFFC;
        end
        if (!lsb_pend && cyc < 3000 && $urandom_range(0, 2) == 0) begin
          lsb_pend = 1; lsb_addr = $urandom | 32'h8000_0000;
          lsb_write = 1'($urandom); lsb_size = 2'($urandom);
          lsb_signed = 1'($urandom); lsb_wdata = $urandom;
        end
        ic_req = ic_pend; lsb_req = lsb_pend;
      end
      rdy = ($urandom_range(0, 4) != 0);
    end
    check("rnd_drained", {29'd0, ic_pend, lsb_pend, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning: max consecutive LSB grants while ic_req is pending before ICache is forced.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; low freezes all state and registered outputs.
REQ-005 clear  input  1  pipeline flush (branch mispredict).
REQ-006 ic_req  input  1  ICache fetch request, held until ic_done.
REQ-007 ic_addr  input  32  fetch address, stable while ic_req.
REQ-008 ic_done  output  1  one-cycle completion pulse.
REQ-009 ic_data  output  32  fetched word, valid with ic_done.
REQ-010 lsb_req  input  1  LSB request, held until lsb_done.
REQ-011 lsb_addr  input  32  access address.
REQ-012 lsb_write  input  1  1 = store, 0 = load.
REQ-013 lsb_size  input  2  0 byte, 1 half, 2 word, 3 treated as word.
REQ-014 lsb_signed  input  1  sign-extend load result.
REQ-015 lsb_wdata  input  32  store data.
REQ-016 lsb_done  output  1  one-cycle completion pulse.
REQ-017 lsb_rdata  output  32  extended load result, valid with lsb_done.
REQ-018 m_valid  output  1  request to byte-serial memory controller.
REQ-019 m_addr / m_write / m_size / m_wdata  output  32/1/2/32  latched request fields.
REQ-020 m_done  input  1  controller completion pulse.
REQ-021 m_rdata  input  32  raw little-endian data, valid with m_done.

Function
REQ-022 States SHALL be IDLE, BUSY_IC, BUSY_LSB, DRAIN, RESP.
REQ-023 IDLE, lsb_req=1, not forced: latch LSB fields, m_valid=1 next cycle, go BUSY_LSB.
REQ-024 IDLE, ic_req=1 and (lsb_req=0 or starve_cnt==STARVE_LIMIT): latch ic_addr, m_write=0, m_size=2, go BUSY_IC.
REQ-025 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each LSB grant with ic_req=1, clear to 0 on each IC grant, hold otherwise.
REQ-026 m_valid and all m_* fields SHALL stay constant from grant until the edge sampling m_done=1; m_valid drops the cycle after.
REQ-027 BUSY_* with m_done=1 SHALL register result and go RESP; RESP asserts exactly one of ic_done/lsb_done for one cycle, then IDLE; no grant is made in RESP.
REQ-028 Grant-to-done latency = controller latency + 2 cycles; back-to-back grants separated by at least one IDLE cycle.
REQ-029 m_wdata SHALL carry lsb_wdata with bytes above size zeroed (byte: [7:0], half: [15:0]).
REQ-030 Load result: byte -> m_rdata[7:0] extended by bit 7 if lsb_signed else zeros; half -> [15:0] extended by bit 15 likewise; word -> m_rdata unchanged.
REQ-031 ic_data/lsb_rdata SHALL hold last value outside done pulses.
REQ-032 clear in IDLE/RESP: suppress any pending done pulse, return IDLE; requests sampled that cycle are ignored.
REQ-033 clear in BUSY_IC, or BUSY_LSB with load: go DRAIN; DRAIN keeps m_valid until m_done, then IDLE with no done pulse.
REQ-034 clear in BUSY_LSB with store: ignored; store completes and lsb_done pulses (committed stores are never dropped).
REQ-035 clear and m_done same cycle: clear wins for fetch/load (no pulse); store pulses lsb_done.
REQ-036 rdy=0 SHALL freeze state, starve_cnt, latched fields and outputs, including mid-transaction; m_done is ignored while rdy=0.

Reset
REQ-037 rst=1 at a rdy=1 edge SHALL force IDLE, starve_cnt=0, m_valid=0, m_write=0, m_size=0, m_addr=0, m_wdata=0, ic_done=0, lsb_done=0, ic_data=0, lsb_rdata=0.
REQ-038 rst mid-transaction SHALL abandon it with no done pulse; rst has priority over clear and m_done.

Verification
REQ-039 ic_req, addr 0x100, m_done after 3 cycles with 0x00C0FFEE -> ic_done one cycle, ic_data=0x00C0FFEE, m_size=2, m_write=0.
REQ-040 LB signed, m_rdata=0x000000F0 -> lsb_rdata=0xFFFFFFF0; LHU, m_rdata=0x0000F0F0 -> 0x0000F0F0.
REQ-041 lsb_req and ic_req held continuously, STARVE_LIMIT=4 -> grant order L,L,L,L,I,L,L,L,L,I.
REQ-042 clear during BUSY_IC and during BUSY_LSB load -> m_valid held until m_done, no done pulse; clear during SW 0x12345678 -> lsb_done pulses.
REQ-043 SB wdata 0xAABBCCDD -> m_wdata=0x000000DD; rdy low 5 cycles mid-access -> m_* and state unchanged, completion resumes.
REQ-044 rst asserted during BUSY_LSB -> all outputs zero next cycle, no lsb_done.
